pipeline_ctrl: RTL and testbench

Central hazard and sequencing controller for the five-stage core: it turns load-use hazards, EX-stage redirects (jumps and taken branches) and data-memory wait states into per-stage stall and flush strobes, plus the PC redirect. It sits beside the pipeline registers, drives their hold and invalidate controls, and keeps stall and flush performance counters.

---
 rtl/orion_types.sv | 23 ++
 rtl/ctrl_perf_cnt.sv | 27 ++
 rtl/pipeline_ctrl.sv | 151 +++++++++++++++
 tb/tb_pipeline_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/orion_types.sv
// Shared types for the core control path.
//   ctrl_state_t        : pipeline_ctrl sequencing states
//   ctrl_stall_t        : the four per-stage hold strobes
//   MEM_TIMEOUT_DEFAULT : default data-access wait limit in cycles
package orion_types;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_REQ  = 2'd1,
      MEM_RESP = 2'd2,
      ERROR    = 2'd3
   } ctrl_state_t;

   typedef struct packed {
      logic if_s;
      logic id_s;
      logic ex_s;
      logic mem_s;
   } ctrl_stall_t;

   localparam int unsigned MEM_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/ctrl_perf_cnt.sv
// Wrapping performance counter.
//   clk_i  : core clock
//   clr_i  : synchronous clear, wins over the enable
//   en_i   : count this cycle
//   cnt_o  : current count, wraps modulo 2^CNT_W
module ctrl_perf_cnt #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk_i,
   input  logic             clr_i,
   input  logic             en_i,
   output logic [CNT_W-1:0] cnt_o
);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk_i) begin
      if (clr_i) begin
         cnt_q <= '0;
      end else if (en_i) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the five-stage core.
// Inputs : clk_i, rst_i (sync, active high), ID/EX/MEM stage status,
//          data-memory grant/rvalid handshake, EX redirect target.
// Outputs: per-stage stall and flush strobes, PC redirect and target,
//          sticky memory timeout flag, stall and redirect counters.
//
// state    | meaning
// ---------+----------------------------------------------------
// RUN      | no data access outstanding
// MEM_REQ  | data access issued, waiting for grant
// MEM_RESP | load granted, waiting for read data
// ERROR    | access exceeded MEM_TIMEOUT, pipeline frozen to reset
module pipeline_ctrl
   import orion_types::*;
#(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned CNT_W       = 32,
   parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             id_valid_i,
   input  logic             id_load_use_i,
   input  logic             ex_valid_i,
   input  logic             ex_redirect_i,
   input  logic [XLEN-1:0]  ex_target_i,
   input  logic             mem_valid_i,
   input  logic             mem_access_i,
   input  logic             mem_is_store_i,
   input  logic             dmem_gnt_i,
   input  logic             dmem_rvalid_i,
   output logic             if_stall_o,
   output logic             id_stall_o,
   output logic             ex_stall_o,
   output logic             mem_stall_o,
   output logic             id_flush_o,
   output logic             ex_flush_o,
   output logic             pc_redirect_o,
   output logic [XLEN-1:0]  pc_target_o,
   output logic             mem_timeout_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o
);

   ctrl_state_t state_q;
   logic [31:0] wait_q;
   logic        timeout_q;

   logic        mem_start;
   logic        mem_done;
   logic        mem_stall;
   logic        wait_hit;
   ctrl_stall_t stall;

   assign mem_start = mem_valid_i && mem_access_i;
   // Stores finish on grant; loads also need data.
   assign mem_done  = dmem_gnt_i && (mem_is_store_i || dmem_rvalid_i);
   // wait_q counts cycles already spent waiting, so +1 includes this one.
   assign wait_hit  = (MEM_TIMEOUT != 0) && ((wait_q + 32'd1) >= MEM_TIMEOUT);

   // The completing cycle of an access is not stalled.
   always_comb begin
      mem_stall = 1'b0;
      case (state_q)
         RUN:      mem_stall = mem_start && !mem_done;
         MEM_REQ:  mem_stall = !mem_done;
         MEM_RESP: mem_stall = !dmem_rvalid_i;
         default:  mem_stall = 1'b1;
      endcase
   end

   always_comb begin
      stall         = '0;
      id_flush_o    = 1'b0;
      ex_flush_o    = 1'b0;
      pc_redirect_o = 1'b0;
      pc_target_o   = '0;
      if (rst_i) begin
         id_flush_o = 1'b1;
         ex_flush_o = 1'b1;
      end else if (mem_stall) begin
         stall = '{if_s: 1'b1, id_s: 1'b1, ex_s: 1'b1, mem_s: 1'b1};
      end else if (ex_valid_i && ex_redirect_i) begin
         // Kills the younger load-use victim in ID as well.
         id_flush_o    = 1'b1;
         ex_flush_o    = 1'b1;
         pc_redirect_o = 1'b1;
         pc_target_o   = ex_target_i;
      end else if (id_valid_i && id_load_use_i) begin
         stall.if_s = 1'b1;
         stall.id_s = 1'b1;
         ex_flush_o = 1'b1;
      end
   end

   assign if_stall_o  = stall.if_s;
   assign id_stall_o  = stall.id_s;
   assign ex_stall_o  = stall.ex_s;
   assign mem_stall_o = stall.mem_s;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= RUN;
         wait_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         case (state_q)
            RUN: begin
               if (mem_start && !dmem_gnt_i) begin
                  state_q <= MEM_REQ;
                  wait_q  <= '0;
               end else if (mem_start && !mem_done) begin
                  state_q <= MEM_RESP;
                  wait_q  <= '0;
               end
            end
            MEM_REQ, MEM_RESP: begin
               if (!mem_stall) begin
                  state_q <= RUN;
               end else if (wait_hit) begin
                  state_q   <= ERROR;
                  timeout_q <= 1'b1;
               end else begin
                  wait_q <= wait_q + 32'd1;
                  if (dmem_gnt_i) begin
                     state_q <= MEM_RESP;
                  end
               end
            end
            default: state_q <= ERROR;
         endcase
      end
   end

   assign mem_timeout_o = timeout_q;

   ctrl_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk_i (clk_i),
      .clr_i (rst_i),
      .en_i  (stall.if_s),
      .cnt_o (stall_cnt_o)
   );

   ctrl_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk_i (clk_i),
      .clr_i (rst_i),
      .en_i  (pc_redirect_o),
      .cnt_o (flush_cnt_o)
   );

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        id_valid_i, id_load_use_i, ex_valid_i, ex_redirect_i;
   logic [31:0] ex_target_i;
   logic        mem_valid_i, mem_access_i, mem_is_store_i, dmem_gnt_i, dmem_rvalid_i;

   logic        if_stall_o, id_stall_o, ex_stall_o, mem_stall_o;
   logic        id_flush_o, ex_flush_o, pc_redirect_o, mem_timeout_o;
   logic [31:0] pc_target_o, stall_cnt_o, flush_cnt_o;

   logic        if_stall_t, id_stall_t, ex_stall_t, mem_stall_t;
   logic        id_flush_t, ex_flush_t, pc_redirect_t, mem_timeout_t;
   logic [31:0] pc_target_t, stall_cnt_t, flush_cnt_t;

   int total = 0;
   int bad   = 0;

   always #5 clk_i = ~clk_i;

   pipeline_ctrl dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .id_valid_i(id_valid_i), .id_load_use_i(id_load_use_i),
      .ex_valid_i(ex_valid_i), .ex_redirect_i(ex_redirect_i), .ex_target_i(ex_target_i),
      .mem_valid_i(mem_valid_i), .mem_access_i(mem_access_i), .mem_is_store_i(mem_is_store_i),
      .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i),
      .if_stall_o(if_stall_o), .id_stall_o(id_stall_o), .ex_stall_o(ex_stall_o),
      .mem_stall_o(mem_stall_o), .id_flush_o(id_flush_o), .ex_flush_o(ex_flush_o),
      .pc_redirect_o(pc_redirect_o), .pc_target_o(pc_target_o),
      .mem_timeout_o(mem_timeout_o), .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
   );

   pipeline_ctrl #(.MEM_TIMEOUT(4)) dut_to (
      .clk_i(clk_i), .rst_i(rst_i),
      .id_valid_i(id_valid_i), .id_load_use_i(id_load_use_i),
      .ex_valid_i(ex_valid_i), .ex_redirect_i(ex_redirect_i), .ex_target_i(ex_target_i),
      .mem_valid_i(mem_valid_i), .mem_access_i(mem_access_i), .mem_is_store_i(mem_is_store_i),
      .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i),
      .if_stall_o(if_stall_t), .id_stall_o(id_stall_t), .ex_stall_o(ex_stall_t),
      .mem_stall_o(mem_stall_t), .id_flush_o(id_flush_t), .ex_flush_o(ex_flush_t),
      .pc_redirect_o(pc_redirect_t), .pc_target_o(pc_target_t),
      .mem_timeout_o(mem_timeout_t), .stall_cnt_o(stall_cnt_t), .flush_cnt_o(flush_cnt_t)
   );

   // Inputs change 1 time unit after the rising edge; checks run 2 units later.
   task automatic next_cyc();
      @(posedge clk_i);
      #1;
   endtask

   task automatic clr_in();
      id_valid_i = 0; id_load_use_i = 0; ex_valid_i = 0; ex_redirect_i = 0;
      ex_target_i = 32'h0; mem_valid_i = 0; mem_access_i = 0; mem_is_store_i = 0;
      dmem_gnt_i = 0; dmem_rvalid_i = 0;
   endtask

   task automatic do_reset();
      next_cyc();
      rst_i = 1'b1;
      clr_in();
      next_cyc();
      rst_i = 1'b0;
   endtask

   task automatic test_reset();
      next_cyc();
      rst_i = 1'b1;
      clr_in();
      ex_valid_i = 1; ex_redirect_i = 1; ex_target_i = 32'hDEAD_BEEF;
      mem_valid_i = 1; mem_access_i = 1; id_valid_i = 1; id_load_use_i = 1;
      #2;
      total++;
      if ({id_flush_o, ex_flush_o} !== 2'b11) begin
         bad++; $display("FAIL rst_flush got=%b want=11", {id_flush_o, ex_flush_o});
      end
      total++;
      if ({if_stall_o, id_stall_o, ex_stall_o, mem_stall_o} !== 4'b0000) begin
         bad++; $display("FAIL rst_stall got=%b want=0000", {if_stall_o, id_stall_o, ex_stall_o, mem_stall_o});
      end
      total++;
      if (pc_redirect_o !== 1'b0 || pc_target_o !== 32'h0) begin
         bad++; $display("FAIL rst_redirect got=%b/%h want=0/0", pc_redirect_o, pc_target_o);
      end
      next_cyc();
      rst_i = 1'b0;
      clr_in();
      #2;
      total++;
      if (stall_cnt_o !== 32'd0 || flush_cnt_o !== 32'd0 || mem_timeout_o !== 1'b0) begin
         bad++; $display("FAIL rst_regs got=%0d/%0d/%b want=0/0/0", stall_cnt_o, flush_cnt_o, mem_timeout_o);
      end
   endtask

   task automatic test_load_use();
      do_reset();
      id_valid_i = 1; id_load_use_i = 1;
      #2;
      total++;
      if ({if_stall_o, id_stall_o, ex_stall_o, mem_stall_o, id_flush_o, ex_flush_o, pc_redirect_o} !== 7'b1100010) begin
         bad++; $display("FAIL lu_active got=%b want=1100010",
            {if_stall_o, id_stall_o, ex_stall_o, mem_stall_o, id_flush_o, ex_flush_o, pc_redirect_o});
      end
      next_cyc();
      id_load_use_i = 0;
      #2;
      total++;
      if ({if_stall_o, id_stall_o, ex_flush_o} !== 3'b000) begin
         bad++; $display("FAIL lu_release got=%b want=000", {if_stall_o, id_stall_o, ex_flush_o});
      end
      total++;
      if (stall_cnt_o !== 32'd1) begin
         bad++; $display("FAIL lu_cnt got=%0d want=1", stall_cnt_o);
      end
   endtask

   task automatic test_redirect();
      do_reset();
      ex_valid_i = 1; ex_redirect_i = 1; ex_target_i = 32'h0000_0100;
      id_valid_i = 1; id_load_use_i = 1;
      #2;
      total++;
      if ({pc_redirect_o, id_flush_o, ex_flush_o, if_stall_o, id_stall_o} !== 5'b11100) begin
         bad++; $display("FAIL redir_ctl got=%b want=11100",
            {pc_redirect_o, id_flush_o, ex_flush_o, if_stall_o, id_stall_o});
      end
      total++;
      if (pc_target_o !== 32'h0000_0100) begin
         bad++; $display("FAIL redir_tgt got=%h want=00000100", pc_target_o);
      end
      next_cyc();
      clr_in();
      ex_target_i = 32'h0000_0300;
      #2;
      total++;
      if (pc_redirect_o !== 1'b0 || pc_target_o !== 32'h0) begin
         bad++; $display("FAIL redir_idle got=%b/%h want=0/0", pc_redirect_o, pc_target_o);
      end
      total++;
      if (flush_cnt_o !== 32'd1 || stall_cnt_o !== 32'd0) begin
         bad++; $display("FAIL redir_cnt got=%0d/%0d want=1/0", flush_cnt_o, stall_cnt_o);
      end
   endtask

   task automatic test_load_wait();
      logic [5:0] gnt_v;
      logic [5:0] rv_v;
      logic [5:0] st_v;
      gnt_v = 6'b000100;
      rv_v  = 6'b100000;
      st_v  = 6'b011111;
      do_reset();
      for (int c = 0; c < 6; c++) begin
         if (c > 0) next_cyc();
         mem_valid_i = 1; mem_access_i = 1; mem_is_store_i = 0;
         dmem_gnt_i = gnt_v[c]; dmem_rvalid_i = rv_v[c];
         #2;
         total++;
         if ({if_stall_o, id_stall_o, ex_stall_o, mem_stall_o} !== {4{st_v[c]}}) begin
            bad++; $display("FAIL ld_wait_c%0d got=%b want=%b", c,
               {if_stall_o, id_stall_o, ex_stall_o, mem_stall_o}, {4{st_v[c]}});
         end
      end
      next_cyc();
      clr_in();
      #2;
      total++;
      if (stall_cnt_o !== 32'd5 || if_stall_o !== 1'b0 || mem_timeout_o !== 1'b0) begin
         bad++; $display("FAIL ld_wait_end got=%0d/%b/%b want=5/0/0", stall_cnt_o, if_stall_o, mem_timeout_o);
      end
   endtask

   task automatic test_hazard_in_wait();
      logic [2:0] gnt_v;
      logic [2:0] rv_v;
      gnt_v = 3'b010;
      rv_v  = 3'b100;
      do_reset();
      for (int c = 0; c < 3; c++) begin
         if (c > 0) next_cyc();
         mem_valid_i = 1; mem_access_i = 1; dmem_gnt_i = gnt_v[c]; dmem_rvalid_i = rv_v[c];
         ex_valid_i = 1; ex_redirect_i = 1; ex_target_i = 32'h0000_0200;
         id_valid_i = 1; id_load_use_i = 1;
         #2;
         if (c < 2) begin
            total++;
            if ({if_stall_o, id_stall_o, ex_stall_o, mem_stall_o, id_flush_o, ex_flush_o, pc_redirect_o} !== 7'b1111000) begin
               bad++; $display("FAIL hz_wait_c%0d got=%b want=1111000", c,
                  {if_stall_o, id_stall_o, ex_stall_o, mem_stall_o, id_flush_o, ex_flush_o, pc_redirect_o});
            end
         end else begin
            total++;
            if ({if_stall_o, id_stall_o, ex_stall_o, mem_stall_o, id_flush_o, ex_flush_o, pc_redirect_o} !== 7'b0000111
                || pc_target_o !== 32'h0000_0200) begin
               bad++; $display("FAIL hz_issue got=%b/%h want=0000111/00000200",
                  {if_stall_o, id_stall_o, ex_stall_o, mem_stall_o, id_flush_o, ex_flush_o, pc_redirect_o}, pc_target_o);
            end
         end
      end
      next_cyc();
      clr_in();
      #2;
      total++;
      if (flush_cnt_o !== 32'd1 || stall_cnt_o !== 32'd2 || pc_redirect_o !== 1'b0) begin
         bad++; $display("FAIL hz_cnt got=%0d/%0d/%b want=1/2/0", flush_cnt_o, stall_cnt_o, pc_redirect_o);
      end
   endtask

   task automatic test_timeout();
      do_reset();
      for (int c = 0; c < 6; c++) begin
         if (c > 0) next_cyc();
         mem_valid_i = 1; mem_access_i = 1;
         #2;
         total++;
         if (mem_timeout_t !== (c == 5) || if_stall_t !== 1'b1) begin
            bad++; $display("FAIL to_c%0d got=%b/%b want=%b/1", c, mem_timeout_t, if_stall_t, (c == 5));
         end
      end
      total++;
      if (stall_cnt_t !== 32'd5) begin
         bad++; $display("FAIL to_cnt got=%0d want=5", stall_cnt_t);
      end
      next_cyc();
      clr_in();
      dmem_gnt_i = 1; dmem_rvalid_i = 1; ex_valid_i = 1; ex_redirect_i = 1; ex_target_i = 32'h40;
      #2;
      total++;
      if ({if_stall_t, id_stall_t, ex_stall_t, mem_stall_t, id_flush_t, ex_flush_t, pc_redirect_t} !== 7'b1111000
          || mem_timeout_t !== 1'b1) begin
         bad++; $display("FAIL to_sticky got=%b/%b want=1111000/1",
            {if_stall_t, id_stall_t, ex_stall_t, mem_stall_t, id_flush_t, ex_flush_t, pc_redirect_t}, mem_timeout_t);
      end
      do_reset();
      #2;
      total++;
      if (mem_timeout_t !== 1'b0 || stall_cnt_t !== 32'd0 || flush_cnt_t !== 32'd0 || if_stall_t !== 1'b0) begin
         bad++; $display("FAIL to_reset got=%b/%0d/%0d/%b want=0/0/0/0",
            mem_timeout_t, stall_cnt_t, flush_cnt_t, if_stall_t);
      end
   endtask

   task automatic test_store();
      do_reset();
      mem_valid_i = 1; mem_access_i = 1; mem_is_store_i = 1; dmem_gnt_i = 1;
      #2;
      total++;
      if (if_stall_o !== 1'b0 || mem_stall_o !== 1'b0) begin
         bad++; $display("FAIL st_same got=%b%b want=00", if_stall_o, mem_stall_o);
      end
      next_cyc();
      dmem_gnt_i = 0;
      #2;
      total++;
      if (mem_stall_o !== 1'b1 || if_stall_o !== 1'b1) begin
         bad++; $display("FAIL st_wait got=%b%b want=11", if_stall_o, mem_stall_o);
      end
      next_cyc();
      dmem_gnt_i = 1;
      #2;
      total++;
      if (mem_stall_o !== 1'b0) begin
         bad++; $display("FAIL st_gnt got=%b want=0", mem_stall_o);
      end
      next_cyc();
      clr_in();
      #2;
      total++;
      if (mem_stall_o !== 1'b0 || stall_cnt_o !== 32'd1) begin
         bad++; $display("FAIL st_after got=%b/%0d want=0/1", mem_stall_o, stall_cnt_o);
      end
      next_cyc();
      mem_valid_i = 1; mem_access_i = 1; mem_is_store_i = 0; dmem_gnt_i = 1; dmem_rvalid_i = 1;
      #2;
      total++;
      if (mem_stall_o !== 1'b0) begin
         bad++; $display("FAIL ld_fast got=%b want=0", mem_stall_o);
      end
      next_cyc();
      clr_in();
      #2;
      total++;
      if (mem_stall_o !== 1'b0 || stall_cnt_o !== 32'd1) begin
         bad++; $display("FAIL ld_fast_after got=%b/%0d want=0/1", mem_stall_o, stall_cnt_o);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_i = 1'b1;
      clr_in();
      test_reset();
      test_load_use();
      test_redirect();
      test_load_wait();
      test_hazard_in_wait();
      test_timeout();
      test_store();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
